// File: rtl/aes_ctr_pkg.sv
// Shared types and widths for the AES-CTR sequencer.
package aes_ctr_pkg;

    localparam int AES_BLK_W = 128;
    localparam int ADDR_W    = 32;
    localparam int FIFO_W    = ADDR_W + AES_BLK_W;   // {destination, ciphertext}

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_AES = 2'd2,
        PUSH     = 2'd3
    } state_t;

endpackage : aes_ctr_pkg

// File: rtl/aes_ctr_watchdog.sv
// Loadable down-counter guarding the wait for the AES core.
// Loading sets the counter to TIMEOUT_CYCLES-1. Each enabled cycle counts one down.
// o_expired is high on the last allowed cycle, which is when the count reaches zero.
module aes_ctr_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Load on job start, then count down while waiting, saturating at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values; blocking here would race other always_ff blocks.
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule : aes_ctr_watchdog

// File: rtl/aes_ctr_sequencer.sv
// AES-CTR job sequencer: captures a job, builds the counter block, runs the AES
// core, XORs the keystream into the plaintext and pushes {destination, ciphertext}.
module aes_ctr_sequencer
    import aes_ctr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CTR_W          = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 write_out,
    input  logic [AES_BLK_W-1:0] key,
    input  logic [AES_BLK_W-1:0] nonce,
    input  logic [ADDR_W-1:0]    destination,
    input  logic [AES_BLK_W-1:0] plain_text,
    output logic                 busy,
    output logic                 aes_start,
    output logic [AES_BLK_W-1:0] aes_key,
    output logic [AES_BLK_W-1:0] aes_block,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_result,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [FIFO_W-1:0]    fifo_wdata,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    state_t               r_state;
    logic [AES_BLK_W-1:0] r_key;
    logic [AES_BLK_W-1:0] r_nonce;
    logic [ADDR_W-1:0]    r_dest;
    logic [AES_BLK_W-1:0] r_pt;
    logic [AES_BLK_W-1:0] r_ct;
    logic [CTR_W-1:0]     r_ctr;
    logic                 r_err_timeout;
    logic                 r_err_overrun;

    logic                 w_wdog_expired;
    logic                 w_new_session;
    logic                 w_fifo_wr;
    logic [CTR_W-1:0]     w_ctr_word;

    // The job key and nonce registers also remember the previous session.
    // A job whose key or nonce differs from them restarts the block counter.
    assign w_new_session = (key != r_key) || (nonce != r_nonce);
    assign w_fifo_wr     = (r_state == PUSH) && !fifo_full;
    assign w_ctr_word    = r_nonce[CTR_W-1:0] + r_ctr;   // wraps mod 2^CTR_W

    aes_ctr_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (HCLK),
        .i_rst     (HRESET),
        .i_load    (r_state == START),
        .i_en      (r_state == WAIT_AES),
        .o_expired (w_wdog_expired)
    );

    // Main FSM together with the job, counter and ciphertext registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            // NOTE: every job, session and counter register is reset, so after HRESET the outputs are 0 and the next job starts with ctr=0.
            r_state <= IDLE;
            r_key   <= '0;
            r_nonce <= '0;
            r_dest  <= '0;
            r_pt    <= '0;
            r_ct    <= '0;
            r_ctr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_out) begin
                        r_key   <= key;
                        r_nonce <= nonce;
                        r_dest  <= destination;
                        r_pt    <= plain_text;
                        if (w_new_session) begin
                            r_ctr <= '0;
                        end
                        r_state <= START;
                    end
                end
                START: begin
                    r_state <= WAIT_AES;
                end
                WAIT_AES: begin
                    if (aes_done) begin
                        r_ct    <= r_pt ^ aes_result;
                        r_state <= PUSH;
                    end else if (w_wdog_expired) begin
                        // The job is discarded and the counter is left untouched.
                        r_state <= IDLE;
                    end
                end
                PUSH: begin
                    if (w_fifo_wr) begin
                        r_ctr   <= r_ctr + 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky error flags, cleared only by HRESET.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if ((r_state == WAIT_AES) && !aes_done && w_wdog_expired) begin
                r_err_timeout <= 1'b1;
            end
            if (write_out && (r_state != IDLE)) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign aes_start   = (r_state == START);
    assign aes_key     = r_key;
    assign aes_block   = {r_nonce[AES_BLK_W-1:CTR_W], w_ctr_word};
    assign fifo_wr     = w_fifo_wr;
    assign fifo_wdata  = {r_dest, r_ct};
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;

endmodule : aes_ctr_sequencer
